// File: rtl/rstack_pkg.sv
// Shared constants and operation decode for the return-address stack controller.
package rstack_pkg;

    localparam int RSTACK_WIDTH = 13;
    localparam int RSTACK_AW    = 4;
    localparam int RSTACK_DEPTH = 16;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_CLEAR,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } rstack_op_e;

    // A push+pop on an empty stack degrades to a plain push; clear wins over everything.
    function automatic rstack_op_e rstack_decode(input logic clear, input logic push,
                                                 input logic pop, input logic empty);
        if (clear)                  return OP_CLEAR;
        if (push && pop && !empty)  return OP_REPLACE;
        if (push)                   return OP_PUSH;
        if (pop)                    return OP_POP;
        return OP_IDLE;
    endfunction

endpackage

// File: rtl/rstack_ctrl.sv
// Return-address stack controller driving an external 16xWIDTH RAM (sync write, async read).
// Define RSTACK_GUARD_EN to block overflow/underflow and raise sticky error flags.
module rstack_ctrl
    import rstack_pkg::*;
#(
    parameter int WIDTH = RSTACK_WIDTH,
    parameter int AW    = RSTACK_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] tos,
    output logic [AW:0]      depth,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic [AW-1:0]    ram_wad,
    output logic [AW-1:0]    ram_rad,
    output logic             ram_wre,
    output logic [WIDTH-1:0] ram_di,
    input  logic [WIDTH-1:0] ram_dout
);

`ifdef RSTACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    localparam logic [AW:0] FULL_CNT = (AW+1)'(1 << AW);

    logic [AW-1:0] sp_q, sp_d;
    logic [AW:0]   depth_q, depth_d;
    logic          is_empty, is_full;
    logic          wre_c;
    rstack_op_e    op;

    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == FULL_CNT);
    assign op       = rstack_decode(clear, push, pop, is_empty);

    always_comb begin
        sp_d    = sp_q;
        depth_d = depth_q;
        wre_c   = 1'b0;
        ram_wad = sp_q;
        ram_di  = push_data;
        case (op)
            OP_CLEAR: begin
                sp_d    = '0;
                depth_d = '0;
            end
            OP_REPLACE: begin
                wre_c   = 1'b1;
                ram_wad = sp_q - AW'(1);
            end
            OP_PUSH: begin
                // Unguarded push on a full stack wraps onto the oldest entry.
                if (!is_full || !GUARD) begin
                    wre_c = 1'b1;
                    sp_d  = sp_q + AW'(1);
                end
                if (!is_full) depth_d = depth_q + (AW+1)'(1);
            end
            OP_POP: begin
                if (!is_empty || !GUARD) sp_d = sp_q - AW'(1);
                if (!is_empty) depth_d = depth_q - (AW+1)'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q    <= '0;
            depth_q <= '0;
        end else begin
            sp_q    <= sp_d;
            depth_q <= depth_d;
        end
    end

`ifdef RSTACK_GUARD_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (op == OP_PUSH && is_full);
        unf_d = unf_q | (op == OP_POP && is_empty);
        if (op == OP_CLEAR) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign ram_wre = wre_c & ~reset;
    assign ram_rad = sp_q - AW'(1);
    assign tos     = ram_dout;
    assign depth   = depth_q;
    assign empty   = is_empty;
    assign full    = is_full;

endmodule

// File: tb/tb_rstack_ctrl.sv
// Scoreboard bench for rstack_ctrl with a behavioural RAM; expectations follow RSTACK_GUARD_EN.
module tb_rstack_ctrl;

`ifdef RSTACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        reset, clear, push, pop;
    logic [12:0] push_data, tos, ram_di, ram_dout;
    logic [4:0]  depth;
    logic        empty, full, overflow, underflow, ram_wre;
    logic [3:0]  ram_wad, ram_rad;
    logic [12:0] mem [16];

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_wr;
        bit          chk_tos;
        logic [12:0] tos;
        logic [4:0]  depth;
        bit          ovf;
        bit          unf;
        int          rad;
        bit          wre;
        logic [3:0]  wad;
        logic [12:0] di;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    rstack_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .tos       (tos),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .ram_wad   (ram_wad),
        .ram_rad   (ram_rad),
        .ram_wre   (ram_wre),
        .ram_di    (ram_di),
        .ram_dout  (ram_dout)
    );

    // External RAM: synchronous write, asynchronous read.
    always @(posedge clk) if (ram_wre) mem[ram_wad] <= ram_di;
    assign ram_dout = mem[ram_rad];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every falling edge consumes all expectations queued for this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.is_wr) begin
                check({nm, ".wre"}, 32'(ram_wre), 32'(e.wre));
                if (e.wre) begin
                    check({nm, ".wad"}, 32'(ram_wad), 32'(e.wad));
                    check({nm, ".di"}, 32'(ram_di), 32'(e.di));
                end
            end else begin
                if (e.chk_tos) check({nm, ".tos"}, 32'(tos), 32'(e.tos));
                check({nm, ".depth"}, 32'(depth), 32'(e.depth));
                check({nm, ".empty"}, 32'(empty), 32'(e.depth == 5'd0));
                check({nm, ".full"}, 32'(full), 32'(e.depth == 5'd16));
                check({nm, ".overflow"}, 32'(overflow), 32'(e.ovf));
                check({nm, ".underflow"}, 32'(underflow), 32'(e.unf));
                if (e.rad >= 0) check({nm, ".rad"}, 32'(ram_rad), 32'(e.rad));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit c, input bit ps, input bit pp, input logic [12:0] d);
        reset = r; clear = c; push = ps; pop = pp; push_data = d;
    endtask

    task automatic exp_wr(input string nm, input bit wre, input logic [3:0] wad, input logic [12:0] di);
        exp_t e;
        e = '{is_wr: 1'b1, chk_tos: 1'b0, tos: '0, depth: '0, ovf: 1'b0, unf: 1'b0,
              rad: -1, wre: wre, wad: wad, di: di};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic exp_st(input string nm, input bit chk_tos, input logic [12:0] t,
                          input logic [4:0] d, input bit ovf, input bit unf, input int rad);
        exp_t e;
        e = '{is_wr: 1'b0, chk_tos: chk_tos, tos: t, depth: d, ovf: ovf, unf: unf,
              rad: rad, wre: 1'b0, wad: '0, di: '0};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        drive(1, 0, 0, 0, 13'h0);
        tick(); tick();

        // Push during reset is suppressed.
        drive(1, 0, 1, 0, 13'h1AA);
        exp_wr("rst_push", 0, 4'd0, 13'h0);
        exp_st("in_rst", 0, 13'h0, 5'd0, 0, 0, 15);
        tick();
        drive(0, 0, 0, 0, 13'h0);
        exp_st("post_rst", 0, 13'h0, 5'd0, 0, 0, 15);
        tick();

        // Three pushes, two pops.
        drive(0, 0, 1, 0, 13'h0AB); exp_wr("push1", 1, 4'd0, 13'h0AB); tick();
        exp_st("after_push1", 1, 13'h0AB, 5'd1, 0, 0, 0);
        drive(0, 0, 1, 0, 13'h1FF); exp_wr("push2", 1, 4'd1, 13'h1FF); tick();
        exp_st("after_push2", 1, 13'h1FF, 5'd2, 0, 0, 1);
        drive(0, 0, 1, 0, 13'h003); exp_wr("push3", 1, 4'd2, 13'h003); tick();
        exp_st("after_push3", 1, 13'h003, 5'd3, 0, 0, 2);
        drive(0, 0, 0, 1, 13'h0); exp_wr("pop1", 0, 4'd0, 13'h0); tick();
        exp_st("after_pop1", 1, 13'h1FF, 5'd2, 0, 0, 1);
        drive(0, 0, 0, 1, 13'h0); exp_wr("pop2", 0, 4'd0, 13'h0); tick();
        exp_st("after_pop2", 1, 13'h0AB, 5'd1, 0, 0, 0);

        // Replace top at depth 2.
        drive(0, 0, 1, 0, 13'h010); exp_wr("push_010", 1, 4'd1, 13'h010); tick();
        exp_st("depth2", 1, 13'h010, 5'd2, 0, 0, 1);
        drive(0, 0, 1, 1, 13'h155); exp_wr("replace", 1, 4'd1, 13'h155); tick();
        exp_st("after_replace", 1, 13'h155, 5'd2, 0, 0, 1);

        // Fill to depth 5, then clear together with a push.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 13'(13'h021 + i));
            exp_wr("push5", 1, 4'(2 + i), 13'(13'h021 + i));
            tick();
        end
        exp_st("depth5", 1, 13'h023, 5'd5, 0, 0, 4);
        drive(0, 1, 1, 0, 13'h0EE); exp_wr("clear_push", 0, 4'd0, 13'h0); tick();
        exp_st("after_clear", 0, 13'h0, 5'd0, 0, 0, 15);

        // Pop on empty, then push.
        drive(0, 0, 0, 1, 13'h0); exp_wr("pop_empty", 0, 4'd0, 13'h0); tick();
        exp_st("after_pop_empty", 0, 13'h0, 5'd0, 0, GUARD, GUARD ? 15 : 14);
        drive(0, 0, 1, 0, 13'h077); exp_wr("push_077", 1, GUARD ? 4'd0 : 4'd15, 13'h077); tick();
        exp_st("after_push_077", 1, 13'h077, 5'd1, 0, GUARD, -1);
        drive(0, 1, 0, 0, 13'h0); tick();
        exp_st("clear2", 0, 13'h0, 5'd0, 0, 0, 15);

        // Push+pop on an empty stack acts as a push.
        drive(0, 0, 1, 1, 13'h0C3); exp_wr("pp_empty", 1, 4'd0, 13'h0C3); tick();
        exp_st("after_pp_empty", 1, 13'h0C3, 5'd1, 0, 0, 0);
        drive(0, 1, 0, 0, 13'h0); tick();
        exp_st("clear3", 0, 13'h0, 5'd0, 0, 0, 15);

        // Fill 1..16, then a 17th push and a pop from full.
        for (int i = 1; i <= 16; i++) begin
            drive(0, 0, 1, 0, 13'(i));
            exp_wr("fill", 1, 4'(i - 1), 13'(i));
            tick();
            exp_st("fill_state", 1, 13'(i), 5'(i), 0, 0, -1);
        end
        drive(0, 0, 1, 0, 13'd17); exp_wr("push17", GUARD ? 1'b0 : 1'b1, 4'd0, 13'd17); tick();
        exp_st("after_push17", 1, GUARD ? 13'd16 : 13'd17, 5'd16, GUARD, 0, GUARD ? 15 : 0);
        drive(0, 0, 0, 1, 13'h0); exp_wr("pop_full", 0, 4'd0, 13'h0); tick();
        exp_st("after_pop_full", 1, GUARD ? 13'd15 : 13'd16, 5'd15, GUARD, 0, -1);
        drive(0, 1, 0, 0, 13'h0); tick();
        exp_st("final_clear", 0, 13'h0, 5'd0, 0, 0, 15);
        drive(0, 0, 0, 0, 13'h0);
        tick(); tick();

        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
